// File: rtl/regfile_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_arbiter
//
// Shares one 16x8 register file between two requesters:
//   A - digit-scan/convert FSM
//   B - display/readback sequencer
// At most one access is granted per cycle. Arbitration is round-robin with a
// bounded burst: an owner that keeps requesting keeps the port for at most
// MAX_BURST consecutive grants while the other side is waiting.
//
// Ports
//   Clk, Rst                 clock (rising edge), asynchronous active-low reset
//   a_req/a_we/a_addr/a_wdata  requester A command (held stable until granted)
//   a_gnt                    combinational grant for A this cycle
//   a_rvalid/a_rdata         registered read response for A (1-cycle latency)
//   b_*                      same set for requester B
//   rf_raddr/rf_waddr        register file addresses (both follow the winner)
//   rf_ren/rf_wen            register file read / write enables
//   rf_wdata                 register file write data
//   rf_rdata                 register file combinational read data
// -----------------------------------------------------------------------------
module regfile_arbiter #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int MAX_BURST = 4
) (
    input  logic              Clk,
    input  logic              Rst,

    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,

    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,

    output logic [ADDR_W-1:0] rf_raddr,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic              rf_ren,
    output logic              rf_wen,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [DATA_W-1:0] rf_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    localparam logic [3:0] MAX_B = 4'(MAX_BURST);

    state_t            state_q, state_d;
    logic [3:0]        burst_q, burst_d;
    // 1 = B was the most recent new owner; reset to B so A wins the first tie.
    logic              last_b_q, last_b_d;

    logic              gnt_a_raw, gnt_b_raw;
    logic              gnt_a, gnt_b;

    logic              a_rvalid_q, a_rvalid_d;
    logic              b_rvalid_q, b_rvalid_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

    // ---- Grant decision and next-state --------------------------------------
    always_comb begin
        gnt_a_raw = 1'b0;
        gnt_b_raw = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (a_req && b_req) begin
                    gnt_a_raw = last_b_q;
                    gnt_b_raw = !last_b_q;
                end else begin
                    gnt_a_raw = a_req;
                    gnt_b_raw = b_req;
                end
            end
            OWN_A: begin
                // Owner keeps the port unless B is waiting and the burst is spent.
                if (a_req && (!b_req || (burst_q < MAX_B))) begin
                    gnt_a_raw = 1'b1;
                end else if (b_req) begin
                    gnt_b_raw = 1'b1;
                end
            end
            OWN_B: begin
                if (b_req && (!a_req || (burst_q < MAX_B))) begin
                    gnt_b_raw = 1'b1;
                end else if (a_req) begin
                    gnt_a_raw = 1'b1;
                end
            end
            default: begin
                gnt_a_raw = 1'b0;
                gnt_b_raw = 1'b0;
            end
        endcase

        // Grants must vanish the moment reset is asserted, not at the next edge.
        gnt_a = gnt_a_raw && Rst;
        gnt_b = gnt_b_raw && Rst;

        state_d  = state_q;
        burst_d  = burst_q;
        last_b_d = last_b_q;

        if (gnt_a) begin
            if (state_q == OWN_A) begin
                burst_d = (burst_q < MAX_B) ? burst_q + 4'd1 : burst_q;
            end else begin
                state_d  = OWN_A;
                burst_d  = 4'd1;
                last_b_d = 1'b0;
            end
        end else if (gnt_b) begin
            if (state_q == OWN_B) begin
                burst_d = (burst_q < MAX_B) ? burst_q + 4'd1 : burst_q;
            end else begin
                state_d  = OWN_B;
                burst_d  = 4'd1;
                last_b_d = 1'b1;
            end
        end else begin
            state_d = IDLE;
            burst_d = 4'd0;
        end
    end

    // ---- Register file port steering (same cycle as the grant) ---------------
    always_comb begin
        // With no grant the address/data simply follow A; enables stay low.
        rf_raddr = gnt_b ? b_addr  : a_addr;
        rf_waddr = gnt_b ? b_addr  : a_addr;
        rf_wdata = gnt_b ? b_wdata : a_wdata;
        rf_wen   = (gnt_a && a_we)  || (gnt_b && b_we);
        rf_ren   = (gnt_a && !a_we) || (gnt_b && !b_we);
    end

    // ---- Read response capture ----------------------------------------------
    always_comb begin
        a_rvalid_d = gnt_a && !a_we;
        b_rvalid_d = gnt_b && !b_we;
        a_rdata_d  = a_rvalid_d ? rf_rdata : a_rdata_q;
        b_rdata_d  = b_rvalid_d ? rf_rdata : b_rdata_q;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q    <= IDLE;
            burst_q    <= 4'd0;
            last_b_q   <= 1'b1;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            burst_q    <= burst_d;
            last_b_q   <= last_b_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
        end
    end

    assign a_gnt    = gnt_a;
    assign b_gnt    = gnt_b;
    assign a_rvalid = a_rvalid_q;
    assign b_rvalid = b_rvalid_q;
    assign a_rdata  = a_rdata_q;
    assign b_rdata  = b_rdata_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_arbiter
//
// Drives both requesters (directed scenarios plus randomized traffic) against
// a behavioural register file. A reference model decides, from the arbitration
// rules, who should be granted each cycle; granted reads push the expected
// data into a per-requester queue that an independent monitor drains whenever
// the DUT's response should appear.
// -----------------------------------------------------------------------------
module tb_regfile_arbiter;

    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 4;
    localparam int MAX_BURST = 4;

    logic              Clk = 1'b0;
    logic              Rst = 1'b0;
    logic              a_req = 1'b0, a_we = 1'b0;
    logic [ADDR_W-1:0] a_addr = '0;
    logic [DATA_W-1:0] a_wdata = '0;
    logic              b_req = 1'b0, b_we = 1'b0;
    logic [ADDR_W-1:0] b_addr = '0;
    logic [DATA_W-1:0] b_wdata = '0;
    logic              a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [DATA_W-1:0] a_rdata, b_rdata;
    logic [ADDR_W-1:0] rf_raddr, rf_waddr;
    logic              rf_ren, rf_wen;
    logic [DATA_W-1:0] rf_wdata, rf_rdata;

    regfile_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_BURST(MAX_BURST)) dut (
        .Clk(Clk), .Rst(Rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .rf_raddr(rf_raddr), .rf_waddr(rf_waddr), .rf_ren(rf_ren), .rf_wen(rf_wen),
        .rf_wdata(rf_wdata), .rf_rdata(rf_rdata)
    );

    initial forever #5 Clk = ~Clk;

    // Behavioural register file: combinational read, write at the clock edge.
    logic [DATA_W-1:0] rf_mem [16];
    assign rf_rdata = rf_mem[rf_raddr];
    always @(posedge Clk) if (rf_wen) rf_mem[rf_waddr] <= rf_wdata;

    // Reference model state: 0 = nobody, 1 = A, 2 = B.
    int                m_owner, m_cnt, m_last;
    logic [DATA_W-1:0] m_mem [16];
    logic [DATA_W-1:0] qa [$];
    logic [DATA_W-1:0] qb [$];
    logic [DATA_W-1:0] last_a, last_b;

    int pct_a = 0, pct_b = 0, we_pct = 0;
    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    function automatic int pick(input logic ra, input logic rb);
        if (!ra && !rb) return 0;
        if (ra && !rb)  return 1;
        if (rb && !ra)  return 2;
        if (m_owner == 0) return (m_last == 1) ? 2 : 1;
        if (m_cnt < MAX_BURST) return m_owner;
        return 3 - m_owner;
    endfunction

    task automatic model_reset();
        m_owner = 0;
        m_cnt   = 0;
        m_last  = 2;
        qa.delete();
        qb.delete();
        last_a  = '0;
        last_b  = '0;
    endtask

    task automatic gen(input int pct, output logic req, output logic we,
                       output logic [ADDR_W-1:0] addr, output logic [DATA_W-1:0] wd);
        req  = (int'($urandom_range(0, 99)) < pct);
        we   = (int'($urandom_range(0, 99)) < we_pct);
        addr = ADDR_W'($urandom_range(0, 15));
        wd   = DATA_W'($urandom);
    endtask

    // Called at posedge+1. rst_ctl: 0 = leave reset alone, 1 = assert, 2 = release.
    task automatic cycle(input int rst_ctl);
        int g;
        if (rst_ctl == 1) begin
            Rst = 1'b0;
            model_reset();
        end else if (rst_ctl == 2) begin
            Rst = 1'b1;
        end
        if (!a_req) gen(pct_a, a_req, a_we, a_addr, a_wdata);
        if (!b_req) gen(pct_b, b_req, b_we, b_addr, b_wdata);
        g = Rst ? pick(a_req, b_req) : 0;

        @(negedge Clk);
        chk("a_gnt", 32'(a_gnt), 32'(g == 1));
        chk("b_gnt", 32'(b_gnt), 32'(g == 2));
        chk("rf_wen", 32'(rf_wen), 32'((g == 1 && a_we) || (g == 2 && b_we)));
        chk("rf_ren", 32'(rf_ren), 32'((g == 1 && !a_we) || (g == 2 && !b_we)));
        if (g == 1) begin
            chk("rf_waddr", 32'(rf_waddr), 32'(a_addr));
            chk("rf_raddr", 32'(rf_raddr), 32'(a_addr));
            if (a_we) chk("rf_wdata", 32'(rf_wdata), 32'(a_wdata));
        end else if (g == 2) begin
            chk("rf_waddr", 32'(rf_waddr), 32'(b_addr));
            chk("rf_raddr", 32'(rf_raddr), 32'(b_addr));
            if (b_we) chk("rf_wdata", 32'(rf_wdata), 32'(b_wdata));
        end

        @(posedge Clk);
        #1;
        if (Rst && g != 0) begin
            if (g == 1) begin
                if (a_we) m_mem[a_addr] = a_wdata;
                else      qa.push_back(m_mem[a_addr]);
                a_req = 1'b0;
            end else begin
                if (b_we) m_mem[b_addr] = b_wdata;
                else      qb.push_back(m_mem[b_addr]);
                b_req = 1'b0;
            end
            if (g == m_owner) begin
                if (m_cnt < MAX_BURST) m_cnt++;
            end else begin
                m_owner = g;
                m_cnt   = 1;
                m_last  = g;
            end
        end else if (Rst) begin
            m_owner = 0;
            m_cnt   = 0;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_a_gnt"},    32'(a_gnt),    32'(0));
        chk({tag, "_b_gnt"},    32'(b_gnt),    32'(0));
        chk({tag, "_rf_wen"},   32'(rf_wen),   32'(0));
        chk({tag, "_rf_ren"},   32'(rf_ren),   32'(0));
        chk({tag, "_a_rvalid"}, 32'(a_rvalid), 32'(0));
        chk({tag, "_b_rvalid"}, 32'(b_rvalid), 32'(0));
        chk({tag, "_a_rdata"},  32'(a_rdata),  32'(0));
        chk({tag, "_b_rdata"},  32'(b_rdata),  32'(0));
    endtask

    // Monitor: a response is due exactly when the model queued one.
    always @(negedge Clk) begin
        if (Rst) begin
            logic exp_va, exp_vb;
            exp_va = (qa.size() != 0);
            exp_vb = (qb.size() != 0);
            chk("a_rvalid", 32'(a_rvalid), 32'(exp_va));
            chk("b_rvalid", 32'(b_rvalid), 32'(exp_vb));
            if (exp_va) last_a = qa.pop_front();
            if (exp_vb) last_b = qb.pop_front();
            chk("a_rdata", 32'(a_rdata), 32'(last_a));
            chk("b_rdata", 32'(b_rdata), 32'(last_b));
        end
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            rf_mem[i] = DATA_W'(8'h30 + i);
            m_mem[i]  = DATA_W'(8'h30 + i);
        end
        model_reset();

        // Reset held with both requesting: nothing may be granted.
        a_req = 1'b1; a_we = 1'b0; a_addr = 4'd0;
        b_req = 1'b1; b_we = 1'b0; b_addr = 4'd5;
        cycle(0);
        cycle(0);
        check_reset_outputs("rst_hold");
        // Release: A wins the first tie, then B is served.
        cycle(2);
        run(3);

        // A alone: write 3 = 0x35, then read it back.
        a_req = 1'b1; a_we = 1'b1; a_addr = 4'd3; a_wdata = 8'h35;
        cycle(0);
        a_req = 1'b1; a_we = 1'b0; a_addr = 4'd3;
        cycle(0);
        run(2);

        // Both reading continuously: bursts of MAX_BURST alternate.
        pct_a = 100; pct_b = 100; we_pct = 0;
        run(24);
        pct_a = 0; pct_b = 0;
        run(4);

        // A alone long enough to saturate the burst, then B joins.
        pct_a = 100;
        run(10);
        pct_b = 100;
        run(4);
        pct_a = 0; pct_b = 0;
        run(4);

        // Make B the last owner so A wins the next tie.
        b_req = 1'b1; b_we = 1'b0; b_addr = 4'd0;
        run(2);

        // Same-cycle write by A and read by B of address 7.
        a_req = 1'b1; a_we = 1'b1; a_addr = 4'd7; a_wdata = 8'h09;
        b_req = 1'b1; b_we = 1'b0; b_addr = 4'd7;
        run(4);

        // Randomized traffic.
        pct_a = 60; pct_b = 60; we_pct = 40;
        run(300);
        pct_a = 0; pct_b = 0;
        run(10);

        // Reset during B's second burst grant with a write pending.
        b_req = 1'b1; b_we = 1'b1; b_addr = 4'd9;  b_wdata = 8'hAA;
        cycle(0);
        b_req = 1'b1; b_we = 1'b1; b_addr = 4'd10; b_wdata = 8'h5C;
        cycle(1);
        cycle(0);
        check_reset_outputs("rst_mid");
        a_req = 1'b1; a_we = 1'b0; a_addr = 4'd10;
        cycle(2);
        run(4);

        pct_a = 50; pct_b = 70; we_pct = 50;
        run(100);
        pct_a = 0; pct_b = 0;
        run(12);

        chk("qa_drained", 32'(qa.size()), 32'(0));
        chk("qb_drained", 32'(qb.size()), 32'(0));
        for (int i = 0; i < 16; i++) chk("rf_contents", 32'(rf_mem[i]), 32'(m_mem[i]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
